dbus_arbiter: RTL and testbench
===============================

// Module: dbus_arbiter
//
// PURPOSE
//   Shares the single data-bus port to the Bridge between two bus masters.
//   Master 0 is the pipelined CPU's MEM stage; master 1 is a DMA/debug master.
//   Each master uses a per-master req/ack handshake. Arbitration is round-robin.
//   A programmable number of wait states is inserted so that slow peripherals can be
//   sampled safely. It sits between myCPU/DMA and the Bridge and replaces the CPU's
//   direct Bus_* connection.
//
// PARAMETERS
//   WAIT_CYCLES  2   extra ACCESS cycles before Bus_rdata is sampled (0..15)
//   CNT_W        4   width of the wait-state counter; must satisfy 2**CNT_W > WAIT_CYCLES
//
// PORTS
//   cpu_clk    in   1   single clock; all state updates on the rising edge
//   cpu_rst    in   1   reset, asynchronous, active-low
//   m0_req     in   1   master 0 request; held high until m0_ack
//   m0_addr    in   32  master 0 byte address
//   m0_we      in   1   master 0 write (1) / read (0)
//   m0_wdata   in   32  master 0 write data
//   m0_ack     out  1   one-cycle pulse: master 0 transaction complete
//   m0_rdata   out  32  master 0 read data, valid while m0_ack is high
//   m1_req/m1_addr/m1_we/m1_wdata/m1_ack/m1_rdata   same as m0, for master 1
//   Bus_addr   out  32  to the Bridge
//   Bus_we     out  1   to the Bridge; write strobe
//   Bus_wdata  out  32  to the Bridge
//   Bus_rdata  in   32  from the Bridge; combinational read data
//   busy       out  1   high in any state other than IDLE
//
// BEHAVIOUR
//   Reset (cpu_rst = 0, async):
//     - state = IDLE; cnt = 0; last_gnt = 1, so master 0 wins the first tie.
//     - Bus_addr, Bus_wdata, m0_rdata and m1_rdata = 0.
//     - Bus_we, m0_ack, m1_ack and busy = 0.
//   FSM states: IDLE -> ACCESS -> RESP -> IDLE. There are no other transitions.
//   IDLE:
//     - With no request pending, remain in IDLE.
//     - With exactly one request pending, grant that master.
//     - With both requests pending, grant the master that is not last_gnt.
//     - On grant, latch the winner's addr/we/wdata and its id (gnt_id), set cnt = WAIT_CYCLES,
//       and move to ACCESS.
//   ACCESS:
//     - Bus_addr and Bus_wdata are driven from the latched registers throughout the state.
//     - Bus_we = latched_we & (cnt == 0): exactly one write-strobe cycle per write.
//     - While cnt != 0: decrement cnt.
//     - When cnt == 0: capture Bus_rdata into the rdata register of gnt_id and move to RESP.
//     - ACCESS therefore lasts WAIT_CYCLES+1 cycles.
//   RESP:
//     - mX_ack = 1 for gnt_id only, for exactly one cycle.
//     - last_gnt is updated to gnt_id and the FSM returns to IDLE.
//   Latency: req sampled at edge k -> ack high during cycle k+WAIT_CYCLES+2.
//   Throughput: one transaction per WAIT_CYCLES+3 cycles, because one IDLE cycle always
//     separates back-to-back transactions.
//   Outputs are decoded from registered state only; ack and Bus_we have no combinational
//     path from any req input.
//   Bus_addr and Bus_wdata hold their last values in IDLE and RESP.
//   Boundary rules:
//     - A request dropped after grant is not aborted; its ack is still issued.
//     - Master inputs are ignored after the grant latch, so changes mid-transfer have no effect.
//     - A req still high in the cycle after ack is treated as a new request.
//     - With both masters requesting continuously, grants alternate strictly; no master
//       waits more than one transaction.
//     - WAIT_CYCLES = 0: ACCESS lasts one cycle; latency is 2.
//     - Reset asserted in ACCESS/RESP: the transaction is dropped, Bus_we deasserts
//       immediately, and no ack is issued.
//     - mX_rdata for writes = Bus_rdata as sampled; its value is don't-care.
//
// STRUCTURE
//   Package dbus_arb_pkg:
//     - state encodings ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2.
//     - master ids M_CPU = 1'b0, M_DMA = 1'b1.
//   Sub-module rr_arb2 (combinational):
//     - inputs req[1:0], last.
//     - outputs gnt_valid, gnt_id.
//     - the top level holds the FSM, the counter and the latches.
//
// TESTING
//   1. Hold cpu_rst = 0 for 3 cycles, then release.
//      -> All outputs are 0, busy = 0, state = IDLE.
//   2. WAIT_CYCLES = 2. m0 read, addr 0xFFFF_F000, Bus_rdata = 0xDEAD_BEEF.
//      -> m0_ack is high exactly 4 cycles after req is sampled.
//      -> m0_rdata = 0xDEAD_BEEF; Bus_we is never high.
//   3. m1 write, addr 0x0000_0100, data 0x1234_5678.
//      -> Bus_we is high for exactly 1 cycle, with Bus_addr = 0x100 and Bus_wdata = 0x1234_5678.
//      -> m1_ack follows on the next cycle.
//   4. m0_req and m1_req raised on the same edge and held for 4 transactions.
//      -> Grant order is m0, m1, m0, m1; acks never overlap.
//   5. Start an m0 write; assert cpu_rst in the first ACCESS cycle.
//      -> No Bus_we pulse, no ack; IDLE after release.
//   6. WAIT_CYCLES = 0. m1 drops req in the cycle after grant.
//      -> m1_ack is still issued, 2 cycles after req was sampled.

Source files
------------

// File: rtl/dbus_arb_pkg.sv
// dbus_arb_pkg: shared FSM state encoding and master ids for the data-bus arbiter
package dbus_arb_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;
  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin pick; a tie goes to the master that did not win last
module rr_arb2 import dbus_arb_pkg::*; (
  input  logic [1:0] req,
  input  logic       last,
  output logic       gnt_valid,
  output logic       gnt_id
);
  always_comb begin
    gnt_valid = |req;
    gnt_id    = &req ? ~last : (req[M_DMA] ? M_DMA : M_CPU);
  end
endmodule

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: round-robin sharing of the Bridge data bus between CPU and DMA masters with programmable wait states
module dbus_arbiter import dbus_arb_pkg::*; #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 4
) (
  input  logic        cpu_clk,
  input  logic        cpu_rst,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_we,
  input  logic [31:0] m0_wdata,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_we,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] Bus_addr,
  output logic        Bus_we,
  output logic [31:0] Bus_wdata,
  input  logic [31:0] Bus_rdata,
  output logic        busy
);
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic last_gnt, gnt_id, gnt_valid, win, lat_we, grant, last_wait;
  rr_arb2 u_arb (
    .req      ({m1_req, m0_req}),
    .last     (last_gnt),
    .gnt_valid(gnt_valid),
    .gnt_id   (win)
  );
  always_comb begin
    grant     = state == ST_IDLE && gnt_valid;
    last_wait = state == ST_ACCESS && cnt == '0;
    state_nx  = grant ? ST_ACCESS : last_wait ? ST_RESP : state == ST_RESP ? ST_IDLE : state;
    Bus_we    = last_wait && lat_we;
    m0_ack    = state == ST_RESP && gnt_id == M_CPU;
    m1_ack    = state == ST_RESP && gnt_id == M_DMA;
    busy      = state != ST_IDLE;
  end
  // Bus_addr/Bus_wdata are the grant latches themselves, so they hold between transfers
  always_ff @(posedge cpu_clk or negedge cpu_rst) begin
    if (!cpu_rst) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      last_gnt  <= M_DMA;
      gnt_id    <= M_CPU;
      lat_we    <= 1'b0;
      Bus_addr  <= '0;
      Bus_wdata <= '0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      state <= state_nx;
      if (grant) begin
        gnt_id    <= win;
        cnt       <= CNT_W'(WAIT_CYCLES);
        Bus_addr  <= win ? m1_addr : m0_addr;
        Bus_wdata <= win ? m1_wdata : m0_wdata;
        lat_we    <= win ? m1_we : m0_we;
      end
      if (state == ST_ACCESS && cnt != '0) cnt <= cnt - 1'b1;
      if (last_wait && gnt_id == M_CPU) m0_rdata <= Bus_rdata;
      if (last_wait && gnt_id == M_DMA) m1_rdata <= Bus_rdata;
      if (state == ST_RESP) last_gnt <= gnt_id;
    end
  end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: scoreboard bench with a transaction-level arbiter model, directed cases plus random traffic
module tb_dbus_arbiter;
  localparam int W = 2;
  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          ack_at;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [1:0] req = '0;
  logic [1:0] we = '0;
  logic [31:0] addr [2];
  logic [31:0] wdata [2];
  logic m0_ack, m1_ack, bus_we, busy;
  logic [31:0] m0_rdata, m1_rdata, bus_addr, bus_wdata, bus_rdata;
  logic z_req = 1'b0;
  logic [31:0] z_addr = '0;
  logic z0_ack, z1_ack, z_bus_we, z_busy;
  logic [31:0] z0_rdata, z1_rdata, z_bus_addr, z_bus_wdata, z_bus_rdata;
  int errors = 0;
  int checks = 0;
  function automatic logic [31:0] bridge(input logic [31:0] a);
    return a == 32'hFFFF_F000 ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0F0F) + 32'd7;
  endfunction
  assign bus_rdata   = bridge(bus_addr);
  assign z_bus_rdata = bridge(z_bus_addr);
  dbus_arbiter #(.WAIT_CYCLES(W), .CNT_W(4)) dut (
    .cpu_clk(clk), .cpu_rst(rst_n),
    .m0_req(req[0]), .m0_addr(addr[0]), .m0_we(we[0]), .m0_wdata(wdata[0]), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(req[1]), .m1_addr(addr[1]), .m1_we(we[1]), .m1_wdata(wdata[1]), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .Bus_addr(bus_addr), .Bus_we(bus_we), .Bus_wdata(bus_wdata), .Bus_rdata(bus_rdata), .busy(busy)
  );
  dbus_arbiter #(.WAIT_CYCLES(0), .CNT_W(4)) u_w0 (
    .cpu_clk(clk), .cpu_rst(rst_n),
    .m0_req(1'b0), .m0_addr(32'h0), .m0_we(1'b0), .m0_wdata(32'h0), .m0_ack(z0_ack), .m0_rdata(z0_rdata),
    .m1_req(z_req), .m1_addr(z_addr), .m1_we(1'b0), .m1_wdata(32'h0), .m1_ack(z1_ack), .m1_rdata(z1_rdata),
    .Bus_addr(z_bus_addr), .Bus_we(z_bus_we), .Bus_wdata(z_bus_wdata), .Bus_rdata(z_bus_rdata), .busy(z_busy)
  );
  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, expv);
    end
  endtask
  function automatic logic ack_of(input int m);
    return m == 1 ? m1_ack : m0_ack;
  endfunction
  // Transaction-level model: a master is served W+3 edges after grant, ack W+1 edges after grant
  exp_t q[$];
  exp_t e, r;
  int cyc = 0;
  int free_at = 0;
  int busy_until = -1;
  logic last = 1'b1;
  int gcnt [2] = '{0, 0};
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      free_at = 0;
      busy_until = -1;
      last = 1'b1;
    end else begin
      cyc++;
      if (cyc >= free_at && req != 2'b00) begin
        e.id     = req == 2'b11 ? ~last : req[1];
        e.addr   = addr[e.id];
        e.we     = we[e.id];
        e.wdata  = wdata[e.id];
        e.rdata  = bridge(addr[e.id]);
        e.ack_at = cyc + W + 1;
        q.push_back(e);
        last = e.id;
        free_at = cyc + W + 3;
        busy_until = cyc + W + 1;
        gcnt[e.id]++;
      end
    end
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      chk({m1_ack, m0_ack, bus_we, busy} == 4'b0, "reset_ctrl", {m1_ack, m0_ack, bus_we, busy}, 0);
      chk({bus_addr, bus_wdata} == 64'h0, "reset_bus", {bus_addr, bus_wdata}, 0);
      chk({m0_rdata, m1_rdata} == 64'h0, "reset_rdata", {m0_rdata, m1_rdata}, 0);
    end else begin
      chk(busy == (cyc <= busy_until), "busy", busy, cyc <= busy_until);
      if (bus_we) begin
        if (q.size() == 0) chk(1'b0, "spurious_we", bus_addr, 0);
        else begin
          chk(q[0].we, "we_on_read", bus_we, q[0].we);
          chk(bus_addr == q[0].addr, "we_addr", bus_addr, q[0].addr);
          chk(bus_wdata == q[0].wdata, "we_wdata", bus_wdata, q[0].wdata);
          chk(cyc == q[0].ack_at - 1, "we_time", cyc, q[0].ack_at - 1);
        end
      end
      if (m0_ack || m1_ack) begin
        if (q.size() == 0) chk(1'b0, "spurious_ack", {m1_ack, m0_ack}, 0);
        else begin
          r = q.pop_front();
          chk({m1_ack, m0_ack} == (r.id ? 2'b10 : 2'b01), "ack_id", {m1_ack, m0_ack}, r.id ? 2'b10 : 2'b01);
          chk(cyc == r.ack_at, "ack_time", cyc, r.ack_at);
          if (!r.we) chk((r.id ? m1_rdata : m0_rdata) == r.rdata, "rdata", r.id ? m1_rdata : m0_rdata, r.rdata);
        end
      end
      if (q.size() != 0 && cyc > q[0].ack_at) begin
        chk(1'b0, "ack_missing", cyc, q[0].ack_at);
        void'(q.pop_front());
      end
    end
  end
  task automatic wait_ack(input logic [1:0] mask, output logic [1:0] got);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (({m1_ack, m0_ack} & mask) == 2'b0 && n < 50);
    got = {m1_ack, m0_ack} & mask;
    if (got == 2'b0) chk(1'b0, "timeout", mask, 0);
  endtask
  task automatic do_txn(input int m, input logic [31:0] a, input logic w, input logic [31:0] d);
    logic [1:0] got;
    @(negedge clk);
    req[m] = 1'b1;
    addr[m] = a;
    we[m] = w;
    wdata[m] = d;
    wait_ack(m == 1 ? 2'b10 : 2'b01, got);
    req[m] = 1'b0;
  endtask
  int want [2] = '{0, 0};
  logic [1:0] pend = '0;
  bit stop = 1'b0;
  task automatic new_req(input int m);
    req[m] = 1'b1;
    pend[m] = 1'b1;
    want[m] = gcnt[m] + 1;
    addr[m] = $urandom;
    wdata[m] = $urandom;
    we[m] = 1'($urandom_range(1));
  endtask
  task automatic rand_step(input int m);
    if (pend[m]) begin
      if (ack_of(m)) begin
        if (!stop && $urandom_range(1) == 1) new_req(m);
        else begin
          pend[m] = 1'b0;
          req[m] = 1'b0;
        end
      end else if (gcnt[m] == want[m] && $urandom_range(3) == 0) begin
        addr[m] = $urandom;
        wdata[m] = $urandom;
        we[m] = ~we[m];
        if ($urandom_range(1) == 1) req[m] = 1'b0;
      end
    end else if (!stop && $urandom_range(2) == 0) new_req(m);
  endtask
  initial begin
    logic [1:0] got;
    logic [3:0] ord;
    addr = '{32'h0, 32'h0};
    wdata = '{32'h0, 32'h0};
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    do_txn(0, 32'hFFFF_F000, 1'b0, 32'h0);
    do_txn(1, 32'h0000_0100, 1'b1, 32'h1234_5678);
    @(negedge clk);
    req = 2'b11;
    we = 2'b00;
    addr = '{32'h0000_1000, 32'h0000_2000};
    for (int i = 0; i < 4; i++) begin
      wait_ack(2'b11, got);
      ord[i] = got[1];
      if (got[0]) addr[0] = addr[0] + 32'h4;
      if (got[1]) addr[1] = addr[1] + 32'h4;
    end
    req = 2'b00;
    chk(ord == 4'b1010, "rr_order", ord, 4'b1010);
    @(negedge clk);
    req[0] = 1'b1;
    we[0] = 1'b1;
    addr[0] = 32'h0000_0200;
    wdata[0] = 32'hCAFE_F00D;
    for (int n = 0; n < 20 && !busy; n++) @(negedge clk);
    chk(busy, "rst_setup", busy, 1);
    #1 rst_n = 1'b0;
    req = 2'b00;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    z_req = 1'b1;
    z_addr = 32'h0000_0300;
    @(negedge clk);
    chk(z_busy && !z1_ack, "w0_grant", {z_busy, z1_ack}, 2'b10);
    z_req = 1'b0;
    z_addr = 32'h0000_BAD0;
    @(negedge clk);
    chk(z1_ack && !z0_ack && !z_bus_we, "w0_ack", {z1_ack, z0_ack, z_bus_we}, 3'b100);
    chk(z1_rdata == bridge(32'h0000_0300), "w0_rdata", z1_rdata, bridge(32'h0000_0300));
    @(negedge clk);
    chk(!z1_ack && !z_busy, "w0_idle", {z1_ack, z_busy}, 2'b00);
    for (int c = 0; c < 2200 && !(c >= 2000 && pend == 2'b00); c++) begin
      @(negedge clk);
      stop = c >= 2000;
      rand_step(0);
      rand_step(1);
    end
    chk(pend == 2'b00, "drain", pend, 0);
    req = 2'b00;
    repeat (8) @(negedge clk);
    chk(q.size() == 0, "queue_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
